// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master, one-slave pipelined Wishbone arbiter.
// Master 0 (fetch) and master 1 (memory stage) share one slave bus.
// The owner keeps the bus until it drops cyc. Simultaneous requests are
// resolved round-robin. Accepted but unacknowledged strobes are counted so
// the slave never sees more than MAX_OUTSTANDING of them.
module wb_arbiter2 #(
    parameter int AW              = 30,
    parameter int DW              = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,

    input  logic              m0_cyc,
    input  logic              m0_stb,
    input  logic              m0_we,
    input  logic [AW-1:0]     m0_addr,
    input  logic [DW-1:0]     m0_mosi,
    input  logic [DW/8-1:0]   m0_sel,
    output logic              m0_ack,
    output logic              m0_stall,
    output logic              m0_err,
    output logic [DW-1:0]     m0_miso,

    input  logic              m1_cyc,
    input  logic              m1_stb,
    input  logic              m1_we,
    input  logic [AW-1:0]     m1_addr,
    input  logic [DW-1:0]     m1_mosi,
    input  logic [DW/8-1:0]   m1_sel,
    output logic              m1_ack,
    output logic              m1_stall,
    output logic              m1_err,
    output logic [DW-1:0]     m1_miso,

    output logic              s_cyc,
    output logic              s_stb,
    output logic              s_we,
    output logic [AW-1:0]     s_addr,
    output logic [DW-1:0]     s_mosi,
    output logic [DW/8-1:0]   s_sel,
    input  logic              s_ack,
    input  logic              s_stall,
    input  logic              s_err,
    input  logic [DW-1:0]     s_miso,

    output logic [1:0]        o_grant
);

    // Grant encoding doubles as the one-hot o_grant value.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } grant_e;

    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    grant_e      grant, grant_nxt;
    logic        last, last_nxt;          // most recently granted master
    logic [3:0]  outstanding, outstanding_nxt;

    logic        req0, req1;
    logic        at_limit;
    logic        limit_block;             // slave window full and no ack frees a slot
    logic        ack_valid;               // ack that matches a pending strobe
    logic        accept;                  // strobe taken by the slave this cycle

    assign req0        = m0_cyc && m0_stb;
    assign req1        = m1_cyc && m1_stb;
    assign at_limit    = (outstanding == MAX_OUT);
    assign limit_block = at_limit && !s_ack;
    assign ack_valid   = s_ack && (outstanding != 4'd0);
    assign accept      = s_stb && !s_stall;

    assign o_grant = grant;
    assign m0_miso = s_miso;
    assign m1_miso = s_miso;

    // State registers: grant owner, round-robin pointer and outstanding count.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            grant       <= IDLE;
            last        <= 1'b1;
            outstanding <= 4'd0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            grant       <= grant_nxt;
            last        <= last_nxt;
            outstanding <= outstanding_nxt;
        end
    end

    // Route the owner's request to the slave and the slave's response back.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_addr   = '0;
        s_mosi   = '0;
        s_sel    = '0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_stall = m0_cyc;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_stall = m1_cyc;
        case (grant)
            G0: begin
                s_cyc    = m0_cyc;
                s_stb    = m0_stb && !limit_block;
                s_we     = m0_we;
                s_addr   = m0_addr;
                s_mosi   = m0_mosi;
                s_sel    = m0_sel;
                m0_ack   = ack_valid;
                m0_err   = s_err;
                m0_stall = s_stall || limit_block;
            end
            G1: begin
                s_cyc    = m1_cyc;
                s_stb    = m1_stb && !limit_block;
                s_we     = m1_we;
                s_addr   = m1_addr;
                s_mosi   = m1_mosi;
                s_sel    = m1_sel;
                m1_ack   = ack_valid;
                m1_err   = s_err;
                m1_stall = s_stall || limit_block;
            end
            default: ;
        endcase
    end

    // Next grant, round-robin pointer and outstanding-count arithmetic.
    always_comb begin
        grant_nxt       = grant;
        last_nxt        = last;
        outstanding_nxt = outstanding;
        case (grant)
            IDLE: begin
                // On a tie, master 0 wins only when master 1 went last.
                if (req0 && (!req1 || last)) begin
                    grant_nxt = G0;
                    last_nxt  = 1'b0;
                end else if (req1) begin
                    grant_nxt = G1;
                    last_nxt  = 1'b1;
                end
            end
            G0, G1: begin
                if ((grant == G0) ? !m0_cyc : !m1_cyc) begin
                    // Release always passes through IDLE for one cycle.
                    grant_nxt       = IDLE;
                    outstanding_nxt = 4'd0;
                end else if (s_err) begin
                    outstanding_nxt = 4'd0;
                end else begin
                    case ({accept, ack_valid})
                        2'b10:   outstanding_nxt = outstanding + 4'd1;
                        2'b01:   outstanding_nxt = outstanding - 4'd1;
                        default: outstanding_nxt = outstanding;
                    endcase
                end
            end
            default: grant_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_wb_arbiter2;

    localparam int AW   = 30;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int MAXO = 2;

    logic            i_clk;
    logic            i_reset_n;
    logic            m0_cyc, m0_stb, m0_we;
    logic [AW-1:0]   m0_addr;
    logic [DW-1:0]   m0_mosi;
    logic [SW-1:0]   m0_sel;
    logic            m0_ack, m0_stall, m0_err;
    logic [DW-1:0]   m0_miso;
    logic            m1_cyc, m1_stb, m1_we;
    logic [AW-1:0]   m1_addr;
    logic [DW-1:0]   m1_mosi;
    logic [SW-1:0]   m1_sel;
    logic            m1_ack, m1_stall, m1_err;
    logic [DW-1:0]   m1_miso;
    logic            s_cyc, s_stb, s_we;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_mosi;
    logic [SW-1:0]   s_sel;
    logic            s_ack, s_stall, s_err;
    logic [DW-1:0]   s_miso;
    logic [1:0]      o_grant;

    wb_arbiter2 #(.AW(AW), .DW(DW), .MAX_OUTSTANDING(MAXO)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_mosi(m0_mosi), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_stall(m0_stall),
        .m0_err(m0_err), .m0_miso(m0_miso),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_mosi(m1_mosi), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_stall(m1_stall),
        .m1_err(m1_err), .m1_miso(m1_miso),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr),
        .s_mosi(s_mosi), .s_sel(s_sel), .s_ack(s_ack), .s_stall(s_stall),
        .s_err(s_err), .s_miso(s_miso),
        .o_grant(o_grant)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected run to complete");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge i_clk);
    endtask

    // Directed vectors: one row per clock cycle, applied back to back.
    typedef struct {
        logic [4:0]    in;      // {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack}
        logic [1:0]    grant;
        logic [1:0]    s;       // {s_cyc, s_stb}
        logic [AW-1:0] saddr;
        logic [3:0]    r;       // {m0_stall, m0_ack, m1_stall, m1_ack}
    } vec_t;

    function automatic vec_t mkv(input logic [4:0] in, input logic [1:0] g,
                                 input logic [1:0] s, input logic [AW-1:0] a,
                                 input logic [3:0] r);
        vec_t v;
        v.in = in; v.grant = g; v.s = s; v.saddr = a; v.r = r;
        return v;
    endfunction

    vec_t vecs[19];

    // Reference model: who owns the bus, who went last, strobes in flight.
    int owner;
    int last_m;
    int pending;

    function automatic logic [140:0] act_vec();
        return {s_cyc, s_stb, s_we, s_addr, s_mosi, s_sel,
                m0_ack, m0_stall, m0_err, m0_miso,
                m1_ack, m1_stall, m1_err, m1_miso, o_grant};
    endfunction

    function automatic logic [140:0] model_expect(output bit acc);
        logic          c[2], st[2], w[2];
        logic [AW-1:0] a[2];
        logic [DW-1:0] d[2];
        logic [SW-1:0] sl[2];
        logic          e_cyc, e_stb, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_mosi;
        logic [SW-1:0] e_sel;
        logic          e_ack[2], e_stall[2], e_err[2];
        logic [1:0]    e_grant;
        bit            full;
        c[0] = m0_cyc;  c[1] = m1_cyc;
        st[0] = m0_stb; st[1] = m1_stb;
        w[0] = m0_we;   w[1] = m1_we;
        a[0] = m0_addr; a[1] = m1_addr;
        d[0] = m0_mosi; d[1] = m1_mosi;
        sl[0] = m0_sel; sl[1] = m1_sel;
        full = (pending == MAXO) && !s_ack;
        e_cyc = 0; e_stb = 0; e_we = 0; e_addr = '0; e_mosi = '0; e_sel = '0;
        e_grant = 2'b00;
        for (int i = 0; i < 2; i++) begin
            e_ack[i] = 0; e_err[i] = 0; e_stall[i] = c[i];
        end
        if (owner >= 0) begin
            e_cyc  = c[owner];
            e_stb  = st[owner] && !full;
            e_we   = w[owner];
            e_addr = a[owner];
            e_mosi = d[owner];
            e_sel  = sl[owner];
            e_ack[owner]   = s_ack && (pending > 0);
            e_err[owner]   = s_err;
            e_stall[owner] = s_stall || full;
            e_grant = (owner == 0) ? 2'b01 : 2'b10;
        end
        acc = e_stb && !s_stall;
        return {e_cyc, e_stb, e_we, e_addr, e_mosi, e_sel,
                e_ack[0], e_stall[0], e_err[0], s_miso,
                e_ack[1], e_stall[1], e_err[1], s_miso, e_grant};
    endfunction

    task automatic model_update(input bit acc);
        bit r0, r1;
        r0 = m0_cyc && m0_stb;
        r1 = m1_cyc && m1_stb;
        if (owner < 0) begin
            if (r0 && r1)  owner = 1 - last_m;
            else if (r0)   owner = 0;
            else if (r1)   owner = 1;
            if (owner >= 0) last_m = owner;
        end else if (!((owner == 0) ? m0_cyc : m1_cyc)) begin
            owner   = -1;
            pending = 0;
        end else if (s_err) begin
            pending = 0;
        end else begin
            pending = pending + (acc ? 1 : 0) - ((s_ack && pending > 0) ? 1 : 0);
        end
    endtask

    int         accepted;
    bit         acc;
    logic [140:0] exp_v;

    initial begin
        i_reset_n = 1'b0;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = 30'h20; m0_mosi = '0; m0_sel = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_addr = 30'h10; m1_mosi = '0; m1_sel = '0;
        s_ack = 0; s_stall = 0; s_err = 0; s_miso = '0;

        // Single read on m1, then three simultaneous requests (m0, m1, m0).
        vecs[0]  = mkv(5'b00000, 2'b00, 2'b00, 30'h00, 4'b0000);
        vecs[1]  = mkv(5'b00110, 2'b00, 2'b00, 30'h00, 4'b0010);
        vecs[2]  = mkv(5'b00110, 2'b10, 2'b11, 30'h10, 4'b0000);
        vecs[3]  = mkv(5'b00101, 2'b10, 2'b10, 30'h10, 4'b0001);
        vecs[4]  = mkv(5'b00000, 2'b10, 2'b00, 30'h10, 4'b0000);
        vecs[5]  = mkv(5'b00000, 2'b00, 2'b00, 30'h00, 4'b0000);
        vecs[6]  = mkv(5'b11110, 2'b00, 2'b00, 30'h00, 4'b1010);
        vecs[7]  = mkv(5'b11110, 2'b01, 2'b11, 30'h20, 4'b0010);
        vecs[8]  = mkv(5'b10111, 2'b01, 2'b10, 30'h20, 4'b0110);
        vecs[9]  = mkv(5'b00110, 2'b01, 2'b00, 30'h20, 4'b0010);
        vecs[10] = mkv(5'b11110, 2'b00, 2'b00, 30'h00, 4'b1010);
        vecs[11] = mkv(5'b11110, 2'b10, 2'b11, 30'h10, 4'b1000);
        vecs[12] = mkv(5'b11101, 2'b10, 2'b10, 30'h10, 4'b1001);
        vecs[13] = mkv(5'b11000, 2'b10, 2'b00, 30'h10, 4'b1000);
        vecs[14] = mkv(5'b11110, 2'b00, 2'b00, 30'h00, 4'b1010);
        vecs[15] = mkv(5'b11110, 2'b01, 2'b11, 30'h20, 4'b0010);
        vecs[16] = mkv(5'b10111, 2'b01, 2'b10, 30'h20, 4'b0110);
        vecs[17] = mkv(5'b00000, 2'b01, 2'b00, 30'h20, 4'b0000);
        vecs[18] = mkv(5'b00000, 2'b00, 2'b00, 30'h00, 4'b0000);

        #12 i_reset_n = 1'b1;
        tick();

        for (int i = 0; i < 19; i++) begin
            {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack} = vecs[i].in;
            s_miso = (i == 3) ? 32'hDEADBEEF : 32'h0000_1000 + 32'(i);
            mid();
            check($sformatf("row%0d o_grant", i), o_grant, vecs[i].grant);
            check($sformatf("row%0d s_cyc", i), s_cyc, vecs[i].s[1]);
            check($sformatf("row%0d s_stb", i), s_stb, vecs[i].s[0]);
            check($sformatf("row%0d s_addr", i), s_addr, vecs[i].saddr);
            check($sformatf("row%0d m0_stall", i), m0_stall, vecs[i].r[3]);
            check($sformatf("row%0d m0_ack", i), m0_ack, vecs[i].r[2]);
            check($sformatf("row%0d m1_stall", i), m1_stall, vecs[i].r[1]);
            check($sformatf("row%0d m1_ack", i), m1_ack, vecs[i].r[0]);
            if (i == 3) check("row3 m1_miso", m1_miso, 32'hDEADBEEF);
            tick();
        end

        // Outstanding limit: four back-to-back strobes, acks withheld.
        s_ack = 0; s_miso = '0;
        m0_cyc = 1; m0_stb = 1; m0_addr = 30'h40;
        mid();
        check("limit arbitration stall", m0_stall, 1'b1);
        tick();
        accepted = 0;
        for (int k = 0; k < 4; k++) begin
            mid();
            if (s_stb && !s_stall) accepted++;
            if (k == 3) check("limit m0_stall held", m0_stall, 1'b1);
            tick();
        end
        check("limit strobes accepted", 32'(accepted), 32'd2);
        s_ack = 1;
        mid();
        check("limit third strobe s_stb", s_stb, 1'b1);
        check("limit third strobe m0_stall", m0_stall, 1'b0);
        check("limit ack forwarded", m0_ack, 1'b1);
        tick();
        s_ack = 0;
        mid();
        check("limit still full", m0_stall, 1'b1);

        // Bus error on a pending write, then a stray ack.
        tick();
        m0_we = 1; s_err = 1;
        mid();
        check("err m0_err", m0_err, 1'b1);
        check("err m1_err", m1_err, 1'b0);
        tick();
        s_err = 0; m0_stb = 0; s_ack = 1;
        mid();
        check("stray ack dropped", m0_ack, 1'b0);
        tick();
        s_ack = 0; m0_stb = 1;
        mid();
        check("err cleared count s_stb", s_stb, 1'b1);
        check("err cleared count m0_stall", m0_stall, 1'b0);
        check("err grant kept", o_grant, 2'b01);
        tick();
        m0_cyc = 0; m0_stb = 0; m0_we = 0;
        tick();
        mid();
        check("release to idle", o_grant, 2'b00);
        tick();

        // Asynchronous reset with two strobes in flight (last owner was m0).
        m0_cyc = 1; m0_stb = 1;
        tick();
        tick();
        tick();
        #1;
        check("pre-reset s_cyc", s_cyc, 1'b1);
        check("pre-reset window full", m0_stall, 1'b1);
        i_reset_n = 0; s_ack = 1; s_err = 1; m1_cyc = 1;
        #1;
        check("reset s_cyc", s_cyc, 1'b0);
        check("reset s_stb", s_stb, 1'b0);
        check("reset o_grant", o_grant, 2'b00);
        check("reset m0_ack", m0_ack, 1'b0);
        check("reset m0_err", m0_err, 1'b0);
        check("reset m0_stall", m0_stall, 1'b1);
        check("reset m1_stall", m1_stall, 1'b1);
        @(posedge i_clk);
        #2;
        i_reset_n = 1; s_ack = 0; s_err = 0; m1_stb = 1;
        mid();
        check("post-reset idle", o_grant, 2'b00);
        tick();
        mid();
        check("post-reset tie to m0", o_grant, 2'b01);
        tick();
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;

        // Randomized traffic against the reference model, from a fresh reset.
        #2 i_reset_n = 0;
        #2 i_reset_n = 1;
        owner = -1; last_m = 1; pending = 0;
        tick();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) m0_cyc = ~m0_cyc;
            if ($urandom_range(7) == 0) m1_cyc = ~m1_cyc;
            m0_stb  = m0_cyc && 1'($urandom_range(1));
            m1_stb  = m1_cyc && 1'($urandom_range(1));
            m0_we   = 1'($urandom_range(1));
            m1_we   = 1'($urandom_range(1));
            m0_addr = AW'($urandom);
            m1_addr = AW'($urandom);
            m0_mosi = $urandom;
            m1_mosi = $urandom;
            m0_sel  = SW'($urandom);
            m1_sel  = SW'($urandom);
            s_ack   = ($urandom_range(2) != 0);
            s_stall = ($urandom_range(3) == 0);
            s_err   = ($urandom_range(31) == 0);
            s_miso  = $urandom;
            mid();
            exp_v = model_expect(acc);
            check($sformatf("rand%0d outputs", n), act_vec(), exp_v);
            @(posedge i_clk);
            model_update(acc);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
